// File: rtl/tmds_period_scheduler.sv
// TMDS period scheduler: pixel-rate strobe, raster sweep, per-pixel period
// classification and sync/CTL generation, all on the TMDS bit clock.
// Frames start and stop only at a fixed park point near the end of the raster.
module tmds_period_scheduler #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int CW       = 10
) (
  input  logic          tmds_bit_clk,
  input  logic          rst_in,
  input  logic          run,
  output logic          pix_ce,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic [1:0]    period,
  output logic [3:0]    ctl,
  output logic          frame_start,
  output logic          running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] PARK_X   = CW'(H_TOTAL - 11);
  localparam logic [CW-1:0] PARK_Y   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] X_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] Y_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] Y_ACT_M1 = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] PRE_BEG  = CW'(H_TOTAL - 10);
  localparam logic [CW-1:0] PRE_END  = CW'(H_TOTAL - 3);
  localparam logic [CW-1:0] GRD_BEG  = CW'(H_TOTAL - 2);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          SP       = 1'(SYNC_POL);

  localparam logic [1:0] P_CONTROL  = 2'd0;
  localparam logic [1:0] P_PREAMBLE = 2'd1;
  localparam logic [1:0] P_GUARD    = 2'd2;
  localparam logic [1:0] P_VIDEO    = 2'd3;

  typedef enum logic {ST_PARKED = 1'b0, ST_RUN = 1'b1} state_t;

  logic [3:0]    r_div;
  logic [CW-1:0] r_x, r_y;
  logic          r_de, r_hsync, r_vsync, r_frame_start;
  logic [1:0]    r_period;
  logic [3:0]    r_ctl;
  state_t        r_state;
  state_t        w_state_nxt;

  logic          w_pix_ce;
  logic          w_at_park;
  logic          w_hold;
  logic [CW-1:0] w_nx, w_ny;
  logic [1:0]    w_per;

  // Classify one pixel; preamble/guard only lead into an active line
  // (the line after the last one is line 0).
  function automatic logic [1:0] f_period(input logic [CW-1:0] px,
                                          input logic [CW-1:0] py);
    logic nl_act;
    nl_act = (py == Y_LAST) || (py < Y_ACT_M1);
    if ((px < X_ACT) && (py < Y_ACT))                    return P_VIDEO;
    else if (nl_act && (px >= PRE_BEG) && (px <= PRE_END)) return P_PREAMBLE;
    else if (nl_act && (px >= GRD_BEG))                  return P_GUARD;
    else                                                 return P_CONTROL;
  endfunction

  assign w_pix_ce  = (r_div == 4'd9);
  assign w_at_park = (r_x == PARK_X) && (r_y == PARK_Y);
  assign w_hold    = w_at_park && !run;
  assign w_nx      = w_hold ? r_x : ((r_x == X_LAST) ? '0 : r_x + 1'b1);
  assign w_ny      = (w_hold || (r_x != X_LAST)) ? r_y
                   : ((r_y == Y_LAST) ? '0 : r_y + 1'b1);
  assign w_per     = f_period(w_nx, w_ny);

  // Divide the bit clock by ten to form the pixel/load strobe.
  always_ff @(posedge tmds_bit_clk or negedge rst_in) begin
    if (!rst_in)       r_div <= 4'd0;
    else if (w_pix_ce) r_div <= 4'd0;
    else               r_div <= r_div + 4'd1;
  end

  // Advance the raster and register the outputs describing the new pixel.
  always_ff @(posedge tmds_bit_clk or negedge rst_in) begin
    if (!rst_in) begin
      r_x           <= PARK_X;
      r_y           <= PARK_Y;
      r_period      <= P_CONTROL;
      r_de          <= 1'b0;
      r_ctl         <= 4'b0000;
      r_hsync       <= ~SP;
      r_vsync       <= ~SP;
      r_frame_start <= 1'b0;
    end else if (w_pix_ce) begin
      r_x           <= w_nx;
      r_y           <= w_ny;
      r_period      <= w_per;
      r_de          <= (w_per == P_VIDEO);
      r_ctl         <= (w_per == P_PREAMBLE) ? 4'b0001 : 4'b0000;
      r_hsync       <= ((w_nx >= HS_BEG) && (w_nx < HS_END)) ? SP : ~SP;
      r_vsync       <= ((w_ny >= VS_BEG) && (w_ny < VS_END)) ? SP : ~SP;
      r_frame_start <= (w_nx == '0) && (w_ny == '0);
    end
  end

  // Park/run state register.
  always_ff @(posedge tmds_bit_clk or negedge rst_in) begin
    if (!rst_in) r_state <= ST_PARKED;
    else         r_state <= w_state_nxt;
  end

  // Next state: decided on each pixel strobe by whether the raster holds.
  always_comb begin
    w_state_nxt = r_state;
    if (w_pix_ce) w_state_nxt = w_hold ? ST_PARKED : ST_RUN;
  end

  // Outputs: running reflects the state, the rest come from the registers.
  always_comb begin
    running     = (r_state == ST_RUN);
    pix_ce      = w_pix_ce;
    x           = r_x;
    y           = r_y;
    de          = r_de;
    hsync       = r_hsync;
    vsync       = r_vsync;
    period      = r_period;
    ctl         = r_ctl;
    frame_start = r_frame_start;
  end

endmodule

// File: doc/tmds_period_scheduler.md
Name: tmds_period_scheduler

Overview:
- Master sequencer for the TMDS transmit path. Runs entirely on tmds_bit_clk.
- Derives the pixel-rate clock enable (bit clock / 10), which doubles as the serializer load strobe.
- Sweeps the 800x525 raster and schedules each pixel period: CONTROL, VIDEO_PREAMBLE, VIDEO_GUARD or VIDEO_ACTIVE.
- Drives the hsync/vsync/CTL inputs of the three channel encoders and the pattern generator.
- Start/stop is frame-synchronous, so the downstream encoders and serializer never see a torn frame.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels after active)
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync lines
- V_BP, 33, vertical back porch
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
- CW, 10, coordinate counter width

Ports:
- tmds_bit_clk  in  1  TMDS bit clock (252 MHz); sole clock
- rst_in  in  1  reset, asynchronous, active-low
- run  in  1  request output of frames; sampled only at the park point
- pix_ce  out  1  one-bit-clock pulse every 10 cycles; pixel enable and serializer load
- x  out  CW  horizontal position, 0..H_TOTAL-1
- y  out  CW  vertical position, 0..V_TOTAL-1
- de  out  1  high only in VIDEO_ACTIVE
- hsync  out  1  horizontal sync at SYNC_POL
- vsync  out  1  vertical sync at SYNC_POL
- period  out  2  0=CONTROL, 1=PREAMBLE, 2=GUARD, 3=VIDEO
- ctl  out  4  CTL3..CTL0 for channels 1/2
- frame_start  out  1  pulse on the pix_ce cycle that enters (0,0)
- running  out  1  high while not parked

Behaviour:
- Derived values:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP = 800.
  - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP = 525.
  - PARK_X = H_TOTAL - 11 = 789; PARK_Y = V_TOTAL - 1 = 524.
- Divider:
  - 4-bit counter div cycles 0..9. pix_ce = 1 on cycles where div == 9, else 0.
  - After reset release, the first pix_ce occurs on the 10th rising edge.
- Raster counters:
  - Advance only on pix_ce. x wraps at H_TOTAL-1 to 0. y increments when x wraps, and wraps at V_TOTAL-1 to 0.
- Parking:
  - When (x,y) == (PARK_X,PARK_Y), run == 0 and pix_ce: counters hold and running = 0.
  - With run == 1 the raster advances normally and running = 1.
  - A running raster always passes the park point, so a stop takes effect only at the end of a frame.
  - Resuming from park always starts with line-0 preamble/guard.
- Period schedule, per pixel at (x,y):
  - VIDEO: x < H_ACTIVE and y < V_ACTIVE.
  - PREAMBLE: H_TOTAL-10 <= x <= H_TOTAL-3, and the next line is active. Next line is y+1, or 0 when y == V_TOTAL-1, and it must be < V_ACTIVE.
  - GUARD: x = H_TOTAL-2 or H_TOTAL-1, same next-line condition.
  - CONTROL: everything else.
- ctl: 4'b0001 in PREAMBLE, 4'b0000 otherwise.
- Sync:
  - hsync = SYNC_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751), else ~SYNC_POL.
  - vsync = SYNC_POL when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491), else ~SYNC_POL.
- Timing:
  - All outputs except pix_ce are registered and update on the same bit-clock edge as the counters, so they always describe the current (x,y).
  - They hold for the 10 bit clocks between pix_ce pulses.
- Reset (rst_in low, asynchronous):
  - div = 0, x = PARK_X, y = PARK_Y, running = 0.
  - period = CONTROL, ctl = 0, de = 0, frame_start = 0, pix_ce = 0.
  - hsync = vsync = ~SYNC_POL.
- Reset mid-frame: takes effect immediately; the current frame is aborted and the next frame restarts from park.
- frame_start: high for exactly the one pix_ce-aligned update that loads (0,0), cleared on the next pix_ce.
- run is ignored everywhere except the park point. Toggling run mid-frame has no effect on the current frame.

Test Plan:
- Reset, then run=1 held: pix_ce period is exactly 10 cycles. First pix_ce moves (789,524) to (790,524) with period=PREAMBLE, ctl=0001. (798,524) gives GUARD. (0,0) gives VIDEO, de=1, frame_start=1.
- Full-frame run, count on pix_ce: per frame de high 307200 pixels, hsync low 96 per line, vsync low for lines 490-491, frame_start once per 420000 pix_ce.
- Line 479 to 480 boundary: at y=479, x=790..799 are CONTROL (next line inactive). Line 524 x=790..797 is PREAMBLE. Line 0..478 tails carry preamble/guard.
- Drop run at y=100 mid-frame: the frame completes; counters park at (789,524) and running=0. Raise run 5000 cycles later: next pix_ce goes to (790,524) and the frame resumes.
- Assert rst_in at (320,240) with de=1: de, ctl and frame_start go 0 and (x,y)=(789,524) immediately, without waiting for a clock edge.
- SYNC_POL=1 build: hsync/vsync idle low and pulse high over the same x/y ranges.
